// File: rtl/ahb_gpio_cmd_master.sv
// AHB-Lite master turning a valid/ready command stream into pipelined single transfers.
// It keeps an address-phase slot and a data-phase slot, returns one response per command and flags long slave stalls.
module ahb_gpio_cmd_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic        stall_err,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [31:0] HWDATA,
   output logic        HSEL,
   output logic        HREADY,
   input  logic        HREADYOUT,
   input  logic [31:0] HRDATA
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [7:0] TIMEOUT_C     = 8'(TIMEOUT);

   // Address-phase slot (A)
   logic        a_valid_q, a_valid_d;
   logic        a_write_q, a_write_d;
   logic [31:0] a_addr_q,  a_addr_d;
   logic [31:0] a_wdata_q, a_wdata_d;
   // Data-phase slot (D); its write data lives directly in the HWDATA register
   logic        d_valid_q, d_valid_d;
   logic        d_write_q, d_write_d;
   logic [31:0] hwdata_q,  hwdata_d;
   // Response and stall monitoring
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_write_q, rsp_write_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [7:0]  stall_cnt_q, stall_cnt_d;
   logic        stall_err_q, stall_err_d;

   logic        accept;

   assign cmd_ready = rst_n && (!a_valid_q || HREADYOUT);
   assign accept    = cmd_valid && cmd_ready;

   always_comb begin
      // NOTE: every next-state signal starts from its current value so no path leaves it unassigned (no latches).
      a_valid_d   = a_valid_q;
      a_write_d   = a_write_q;
      a_addr_d    = a_addr_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_write_d   = d_write_q;
      hwdata_d    = hwdata_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      stall_cnt_d = 8'd0;
      stall_err_d = stall_err_q;

      if (HREADYOUT) begin
         d_valid_d = a_valid_q;
         d_write_d = a_write_q;
         if (a_valid_q && a_write_q) hwdata_d = a_wdata_q;
         a_valid_d = accept;
      end else if (accept) begin
         // A was empty during a wait state: the new command may still enter A
         a_valid_d = 1'b1;
      end

      // Address is kept after A empties so HADDR holds its last value
      if (accept) begin
         a_write_d = cmd_write;
         a_addr_d  = cmd_addr;
         a_wdata_d = cmd_wdata;
      end

      if (d_valid_q && HREADYOUT) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = d_write_q;
         rsp_rdata_d = d_write_q ? 32'd0 : HRDATA;
      end

      if (d_valid_q && !HREADYOUT) begin
         stall_cnt_d = (stall_cnt_q == 8'hFF) ? stall_cnt_q : stall_cnt_q + 8'd1;
      end
      if (stall_cnt_d >= TIMEOUT_C) stall_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q   <= 1'b0;
         a_write_q   <= 1'b0;
         a_addr_q    <= 32'd0;
         a_wdata_q   <= 32'd0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         hwdata_q    <= 32'd0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= 32'd0;
         stall_cnt_q <= 8'd0;
         stall_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         a_valid_q   <= a_valid_d;
         a_write_q   <= a_write_d;
         a_addr_q    <= a_addr_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         hwdata_q    <= hwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   assign HTRANS    = a_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HSEL      = a_valid_q;
   assign HWRITE    = a_valid_q && a_write_q;
   assign HADDR     = a_addr_q;
   assign HWDATA    = hwdata_q;
   assign HREADY    = HREADYOUT;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign stall_err = stall_err_q;

endmodule

// File: tb/tb_ahb_gpio_cmd_master.sv
// Directed bench for ahb_gpio_cmd_master: latency, pipelining, wait states, timeout and reset.
module tb_ahb_gpio_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_write;
   logic [31:0] rsp_rdata;
   logic        stall_err;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic        HWRITE, HSEL, HREADY, HREADYOUT;

   int n_checks = 0;
   int n_errors = 0;

   ahb_gpio_cmd_master #(.TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
      .stall_err(stall_err),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HSEL(HSEL), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wdata;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = 32'd0; cmd_wdata = 32'd0;
      HREADYOUT = 1'b1; HRDATA = 32'd0;

      // Reset values
      #2;
      check("rst_htrans", 32'(HTRANS), 32'h0);
      check("rst_hsel", 32'(HSEL), 32'h0);
      check("rst_haddr", HADDR, 32'h0);
      check("rst_hwdata", HWDATA, 32'h0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_stall_err", 32'(stall_err), 32'h0);
      step(); step();
      rst_n = 1'b1;
      #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

      // Single write, zero wait
      drive_cmd(1'b1, 32'h0000_0004, 32'h0001_ABCD);
      step();
      cmd_valid = 1'b0;
      check("wr_addr_htrans", 32'(HTRANS), 32'h2);
      check("wr_addr_hsel", 32'(HSEL), 32'h1);
      check("wr_addr_hwrite", 32'(HWRITE), 32'h1);
      check("wr_addr_haddr", HADDR, 32'h4);
      check("wr_addr_rsp_valid", 32'(rsp_valid), 32'h0);
      step();
      check("wr_data_htrans", 32'(HTRANS), 32'h0);
      check("wr_data_hwrite", 32'(HWRITE), 32'h0);
      check("wr_data_haddr_hold", HADDR, 32'h4);
      check("wr_data_hwdata", HWDATA, 32'h0001_ABCD);
      step();
      check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("wr_rsp_write", 32'(rsp_write), 32'h1);
      check("wr_rsp_rdata", rsp_rdata, 32'h0);
      step();
      check("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

      // Single read, zero wait
      HRDATA = 32'h0000_1234;
      drive_cmd(1'b0, 32'h0000_0000, 32'hDEAD_BEEF);
      step();
      cmd_valid = 1'b0;
      check("rd_addr_htrans", 32'(HTRANS), 32'h2);
      check("rd_addr_hwrite", 32'(HWRITE), 32'h0);
      check("rd_addr_haddr", HADDR, 32'h0);
      step();
      check("rd_data_hwdata_hold", HWDATA, 32'h0001_ABCD);
      step();
      check("rd_rsp_valid", 32'(rsp_valid), 32'h1);
      check("rd_rsp_write", 32'(rsp_write), 32'h0);
      check("rd_rsp_rdata", rsp_rdata, 32'h0000_1234);
      step();

      // Four back-to-back writes
      for (int k = 0; k < 7; k++) begin
         if (k < 4) drive_cmd(1'b1, 32'h10 + 32'(4 * k), 32'hA0 + 32'(k));
         else cmd_valid = 1'b0;
         step();
         if (k < 4) begin
            check($sformatf("b2b_htrans_%0d", k), 32'(HTRANS), 32'h2);
            check($sformatf("b2b_haddr_%0d", k), HADDR, 32'h10 + 32'(4 * k));
         end
         if (k >= 1 && k <= 4)
            check($sformatf("b2b_hwdata_%0d", k), HWDATA, 32'hA0 + 32'(k - 1));
         check($sformatf("b2b_rsp_valid_%0d", k), 32'(rsp_valid),
               (k >= 2 && k <= 5) ? 32'h1 : 32'h0);
      end

      // Read stalled 3 cycles in data phase, write queued behind it
      HRDATA = 32'hCAFE_0001;
      drive_cmd(1'b0, 32'h20, 32'h0);
      step();
      drive_cmd(1'b1, 32'h24, 32'h77);
      check("st_cmd_ready_open", 32'(cmd_ready), 32'h1);
      step();
      cmd_valid = 1'b0;
      HREADYOUT = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("st_haddr_%0d", i), HADDR, 32'h24);
         check($sformatf("st_htrans_%0d", i), 32'(HTRANS), 32'h2);
         check($sformatf("st_hready_%0d", i), 32'(HREADY), 32'h0);
         check($sformatf("st_cmd_ready_%0d", i), 32'(cmd_ready), 32'h0);
         check($sformatf("st_rsp_valid_%0d", i), 32'(rsp_valid), 32'h0);
         step();
      end
      HREADYOUT = 1'b1;
      step();
      check("st_rd_rsp_valid", 32'(rsp_valid), 32'h1);
      check("st_rd_rsp_write", 32'(rsp_write), 32'h0);
      check("st_rd_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
      check("st_stall_err", 32'(stall_err), 32'h0);
      check("st_wr_hwdata", HWDATA, 32'h77);
      step();
      check("st_wr_rsp_valid", 32'(rsp_valid), 32'h1);
      check("st_wr_rsp_write", 32'(rsp_write), 32'h1);
      check("st_wr_rsp_rdata", rsp_rdata, 32'h0);
      step();

      // Timeout: 16 stalled edges set stall_err
      drive_cmd(1'b0, 32'h30, 32'h0);
      step();
      cmd_valid = 1'b0;
      step();
      HREADYOUT = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("to_before_limit", 32'(stall_err), 32'h0);
      step();
      check("to_at_limit", 32'(stall_err), 32'h1);
      HREADYOUT = 1'b1;
      step();
      check("to_rsp_valid", 32'(rsp_valid), 32'h1);
      step();
      check("to_sticky", 32'(stall_err), 32'h1);

      // Reset during the data phase of a write
      drive_cmd(1'b1, 32'h40, 32'h5A5A_5A5A);
      step();
      cmd_valid = 1'b0;
      step();
      check("rr_pre_hwdata", HWDATA, 32'h5A5A_5A5A);
      rst_n = 1'b0;
      #1;
      check("rr_htrans", 32'(HTRANS), 32'h0);
      check("rr_hsel", 32'(HSEL), 32'h0);
      check("rr_haddr", HADDR, 32'h0);
      check("rr_hwdata", HWDATA, 32'h0);
      check("rr_stall_err", 32'(stall_err), 32'h0);
      check("rr_cmd_ready", 32'(cmd_ready), 32'h0);
      step();
      check("rr_no_rsp_0", 32'(rsp_valid), 32'h0);
      step();
      check("rr_no_rsp_1", 32'(rsp_valid), 32'h0);
      rst_n = 1'b1;
      HRDATA = 32'h0000_0BEE;
      drive_cmd(1'b0, 32'h8, 32'h0);
      #1;
      check("rr_release_cmd_ready", 32'(cmd_ready), 32'h1);
      step();
      cmd_valid = 1'b0;
      check("rr_new_htrans", 32'(HTRANS), 32'h2);
      check("rr_new_haddr", HADDR, 32'h8);
      check("rr_new_no_rsp", 32'(rsp_valid), 32'h0);
      step();
      step();
      check("rr_new_rsp_valid", 32'(rsp_valid), 32'h1);
      check("rr_new_rsp_rdata", rsp_rdata, 32'h0000_0BEE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
      $finish;
   end

endmodule
